// File: rtl/cpu_dma_tx_arbiter.sv
// cpu_dma_tx_arbiter
//   Shares one host-facing DMA read channel between NUM_QUEUES CPU DMA
//   transmit queues. A queue holding a complete packet is picked in
//   round-robin order. The arbiter then stays locked on that queue from the
//   length header word through the last body word (non-zero ctrl). After
//   that it releases and spends one IDLE cycle re-arbitrating.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   arb_enable      allows new grants (a packet in progress always completes)
//   q_pkt_avail     per-queue "complete packet present"
//   q_rd_rdy        per-queue "word valid"
//   q_rd_data/ctrl  per-queue word, queue i at slice i
//   q_rd            per-queue read strobe (one-hot or zero)
//   dma_pkt_avail   packet granted and being presented
//   dma_q_num       granted queue index
//   dma_rd_rdy      word valid from the granted queue
//   dma_rd_data/ctrl word from the granted queue
//   dma_rd          read strobe from the DMA engine
//   pkt_granted     one-cycle pulse, first HDR cycle of a grant
//   pkt_done        one-cycle pulse after the last word is read
//   rd_underrun     one-cycle pulse after dma_rd with dma_rd_rdy low (HDR/BODY)
module cpu_dma_tx_arbiter #(
  parameter int unsigned NUM_QUEUES     = 4,
  parameter int unsigned DMA_DATA_WIDTH = 32,
  parameter int unsigned DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
  parameter int unsigned QSEL_WIDTH     = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 arb_enable,
  input  logic [NUM_QUEUES-1:0]                q_pkt_avail,
  input  logic [NUM_QUEUES-1:0]                q_rd_rdy,
  input  logic [NUM_QUEUES*DMA_DATA_WIDTH-1:0] q_rd_data,
  input  logic [NUM_QUEUES*DMA_CTRL_WIDTH-1:0] q_rd_ctrl,
  output logic [NUM_QUEUES-1:0]                q_rd,
  output logic                                 dma_pkt_avail,
  output logic [QSEL_WIDTH-1:0]                dma_q_num,
  output logic                                 dma_rd_rdy,
  output logic [DMA_DATA_WIDTH-1:0]            dma_rd_data,
  output logic [DMA_CTRL_WIDTH-1:0]            dma_rd_ctrl,
  input  logic                                 dma_rd,
  output logic                                 pkt_granted,
  output logic                                 pkt_done,
  output logic                                 rd_underrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [QSEL_WIDTH-1:0]     r_sel;
  logic [QSEL_WIDTH-1:0]     r_last_grant;
  logic                      r_pkt_granted;
  logic                      r_pkt_done;
  logic                      r_rd_underrun;

  logic [QSEL_WIDTH-1:0]     w_winner;
  logic [QSEL_WIDTH-1:0]     w_rr_idx;
  logic                      w_found;
  logic                      w_grant;
  logic                      w_locked;
  logic                      w_sel_rdy;
  logic [DMA_DATA_WIDTH-1:0] w_sel_data;
  logic [DMA_CTRL_WIDTH-1:0] w_sel_ctrl;
  logic                      w_rd_ok;
  logic                      w_last_word;

  // Round-robin search starting just after the last served queue, so the
  // queue served most recently has the lowest priority.
  always_comb begin
    w_winner = '0;
    w_rr_idx = '0;
    w_found  = 1'b0;
    for (int unsigned k = 1; k <= NUM_QUEUES; k++) begin
      w_rr_idx = QSEL_WIDTH'((32'(r_last_grant) + k) % NUM_QUEUES);
      if (!w_found && q_pkt_avail[w_rr_idx]) begin
        w_found  = 1'b1;
        w_winner = w_rr_idx;
      end
    end
  end

  always_comb begin
    w_sel_rdy  = q_rd_rdy[r_sel];
    w_sel_data = q_rd_data[r_sel*DMA_DATA_WIDTH +: DMA_DATA_WIDTH];
    w_sel_ctrl = q_rd_ctrl[r_sel*DMA_CTRL_WIDTH +: DMA_CTRL_WIDTH];
  end

  assign w_locked    = (r_state != ST_IDLE);
  assign w_rd_ok     = w_locked && dma_rd && w_sel_rdy;
  assign w_last_word = (r_state == ST_BODY) && w_rd_ok && (w_sel_ctrl != '0);

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (arb_enable && w_found) begin
          w_grant      = 1'b1;
          w_state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_rd_ok) begin
          w_state_next = ST_BODY;
        end
      end
      ST_BODY: begin
        if (w_last_word) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Everything towards the engine is forced to zero while IDLE so the engine
  // never sees a stale word between packets.
  always_comb begin
    q_rd          = '0;
    dma_pkt_avail = w_locked;
    dma_q_num     = '0;
    dma_rd_rdy    = 1'b0;
    dma_rd_data   = '0;
    dma_rd_ctrl   = '0;
    if (w_locked) begin
      dma_q_num   = r_sel;
      dma_rd_rdy  = w_sel_rdy;
      dma_rd_data = w_sel_data;
      dma_rd_ctrl = w_sel_ctrl;
    end
    if (w_rd_ok) begin
      q_rd[r_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_sel         <= '0;
      r_last_grant  <= QSEL_WIDTH'(NUM_QUEUES - 1);
      r_pkt_granted <= 1'b0;
      r_pkt_done    <= 1'b0;
      r_rd_underrun <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pkt_granted <= w_grant;
      r_pkt_done    <= w_last_word;
      r_rd_underrun <= w_locked && dma_rd && !w_sel_rdy;
      if (w_grant) begin
        r_sel <= w_winner;
      end
      if (w_last_word) begin
        r_last_grant <= r_sel;
      end
    end
  end

  assign pkt_granted = r_pkt_granted;
  assign pkt_done    = r_pkt_done;
  assign rd_underrun = r_rd_underrun;

endmodule

// File: tb/tb_cpu_dma_tx_arbiter.sv
module tb_cpu_dma_tx_arbiter;

  localparam int NQ = 4;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int QW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             arb_enable;
  logic [NQ-1:0]    q_pkt_avail;
  logic [NQ-1:0]    q_rd_rdy;
  logic [NQ*DW-1:0] q_rd_data;
  logic [NQ*CW-1:0] q_rd_ctrl;
  logic [NQ-1:0]    q_rd;
  logic             dma_pkt_avail;
  logic [QW-1:0]    dma_q_num;
  logic             dma_rd_rdy;
  logic [DW-1:0]    dma_rd_data;
  logic [CW-1:0]    dma_rd_ctrl;
  logic             dma_rd;
  logic             pkt_granted;
  logic             pkt_done;
  logic             rd_underrun;

  always #5 clk = ~clk;

  cpu_dma_tx_arbiter #(
    .NUM_QUEUES    (NQ),
    .DMA_DATA_WIDTH(DW),
    .DMA_CTRL_WIDTH(CW),
    .QSEL_WIDTH    (QW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arb_enable   (arb_enable),
    .q_pkt_avail  (q_pkt_avail),
    .q_rd_rdy     (q_rd_rdy),
    .q_rd_data    (q_rd_data),
    .q_rd_ctrl    (q_rd_ctrl),
    .q_rd         (q_rd),
    .dma_pkt_avail(dma_pkt_avail),
    .dma_q_num    (dma_q_num),
    .dma_rd_rdy   (dma_rd_rdy),
    .dma_rd_data  (dma_rd_data),
    .dma_rd_ctrl  (dma_rd_ctrl),
    .dma_rd       (dma_rd),
    .pkt_granted  (pkt_granted),
    .pkt_done     (pkt_done),
    .rd_underrun  (rd_underrun)
  );

  // Simple queue sources: every loaded packet is complete, so "packet
  // available" is simply "source not empty".
  logic [35:0] src_mem  [NQ][32];
  logic [4:0]  src_head [NQ] = '{default: '0};
  logic [4:0]  src_tail [NQ];
  logic [NQ-1:0] rdy_en;
  logic          flush;

  always_comb begin
    q_pkt_avail = '0;
    q_rd_rdy    = '0;
    q_rd_data   = '0;
    q_rd_ctrl   = '0;
    for (int i = 0; i < NQ; i++) begin
      q_pkt_avail[i]         = (src_head[i] != src_tail[i]);
      q_rd_rdy[i]            = q_pkt_avail[i] && rdy_en[i];
      q_rd_data[i*DW +: DW]  = src_mem[i][src_head[i]][31:0];
      q_rd_ctrl[i*CW +: CW]  = src_mem[i][src_head[i]][35:32];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (flush) src_head[i] <= src_tail[i];
      else if (q_rd[i]) src_head[i] <= src_head[i] + 5'd1;
    end
  end

  typedef struct {
    logic [1:0]  q;
    logic [31:0] d;
    logic [3:0]  c;
    bit          is_last;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] grant_q[$];
  int         checks   = 0;
  int         failures = 0;
  bit         done_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] q, input logic [31:0] d, input logic [3:0] c);
    src_mem[q][src_tail[q]] = {c, d};
    src_tail[q] = src_tail[q] + 5'd1;
  endtask

  // Header word = base (ctrl 0); body word w = base+w, the last with lastc.
  // Only the first nexp words are expected to be read by the engine.
  task automatic pkt(input logic [1:0] q, input logic [31:0] base, input int nbody,
                     input logic [3:0] lastc, input int nexp);
    for (int w = 0; w <= nbody; w++) begin
      logic [3:0] c;
      exp_t e;
      c = (w == nbody) ? lastc : 4'h0;
      put(q, base + 32'(w), c);
      if (w < nexp) begin
        e.q = q; e.d = base + 32'(w); e.c = c; e.is_last = (w == nbody);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_grant(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (pkt_granted) break;
    end
    chk("grant_wait", 32'(pkt_granted), 32'd1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (pkt_done) break;
    end
    chk("done_wait", 32'(pkt_done), 32'd1);
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0 && grant_q.size() == 0) break;
      tick();
    end
    chk("drain_words", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q_rd"},        32'(q_rd),          32'd0);
    chk({tag, "_pkt_avail"},   32'(dma_pkt_avail), 32'd0);
    chk({tag, "_q_num"},       32'(dma_q_num),     32'd0);
    chk({tag, "_rd_rdy"},      32'(dma_rd_rdy),    32'd0);
    chk({tag, "_data"},        dma_rd_data,        32'd0);
    chk({tag, "_ctrl"},        32'(dma_rd_ctrl),   32'd0);
    chk({tag, "_granted"},     32'(pkt_granted),   32'd0);
    chk({tag, "_done"},        32'(pkt_done),      32'd0);
    chk({tag, "_underrun"},    32'(rd_underrun),   32'd0);
  endtask

  // Monitor: compares every word transfer, grant and pkt_done pulse against
  // the expectations queued by the stimulus.
  initial begin
    exp_t       e;
    logic [1:0] g;
    forever begin
      @(negedge clk);
      if (reset) begin
        done_pending = 1'b0;
      end else begin
        if (pkt_granted) begin
          chk("grant_expected", 32'(grant_q.size() != 0), 32'd1);
          if (grant_q.size() != 0) begin
            g = grant_q.pop_front();
            chk("grant_q_num", 32'(dma_q_num), 32'(g));
          end
        end
        if (pkt_done || done_pending) chk("pkt_done_pulse", 32'(pkt_done), 32'(done_pending));
        done_pending = 1'b0;
        if (dma_rd && dma_rd_rdy) begin
          chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word_q_num", 32'(dma_q_num), 32'(e.q));
            chk("word_data",  dma_rd_data,    e.d);
            chk("word_ctrl",  32'(dma_rd_ctrl), 32'(e.c));
            chk("word_q_rd",  32'(q_rd), 32'(4'b0001 << e.q));
            done_pending = e.is_last;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    arb_enable = 1'b0;
    dma_rd     = 1'b0;
    rdy_en     = '1;
    flush      = 1'b0;
    for (int i = 0; i < NQ; i++) src_tail[i] = '0;

    // Reset state
    repeat (2) tick();
    chk_all_zero("reset");
    reset  = 1'b0;
    dma_rd = 1'b1;
    tick();
    chk("idle_rd_no_underrun", 32'(rd_underrun), 32'd0);
    chk("idle_pkt_avail", 32'(dma_pkt_avail), 32'd0);

    // Single request on queue 2, header 0x3C
    dma_rd     = 1'b0;
    arb_enable = 1'b1;
    grant_q.push_back(2'd2);
    pkt(2'd2, 32'h3C, 1, 4'h8, 2);
    tick();
    chk("t1_granted",  32'(pkt_granted),   32'd1);
    chk("t1_avail",    32'(dma_pkt_avail), 32'd1);
    chk("t1_q_num",    32'(dma_q_num),     32'd2);
    chk("t1_hdr_data", dma_rd_data,        32'h3C);
    chk("t1_rd_rdy",   32'(dma_rd_rdy),    32'd1);
    chk("t1_q_rd_idle", 32'(q_rd),         32'd0);
    dma_rd = 1'b1;
    #1;
    chk("t1_q_rd", 32'(q_rd), 32'b0100);
    wait_done(10);
    chk("t1_bubble_avail", 32'(dma_pkt_avail), 32'd0);

    // Queue 1: header + 3 body words, last ctrl 0x8
    grant_q.push_back(2'd1);
    pkt(2'd1, 32'h100, 3, 4'h8, 4);
    wait_done(20);
    chk("t2_bubble_avail", 32'(dma_pkt_avail), 32'd0);
    chk("t2_bubble_rdy",   32'(dma_rd_rdy),    32'd0);

    // Round robin from reset: all queues requesting
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grant_q.push_back(2'd0); grant_q.push_back(2'd1); grant_q.push_back(2'd2);
    grant_q.push_back(2'd3); grant_q.push_back(2'd0); grant_q.push_back(2'd1);
    pkt(2'd0, 32'hA00, 1, 4'h1, 2);
    pkt(2'd1, 32'hB00, 1, 4'h1, 2);
    pkt(2'd2, 32'hC00, 1, 4'h1, 2);
    pkt(2'd3, 32'hD00, 1, 4'h1, 2);
    pkt(2'd0, 32'hA10, 1, 4'h1, 2);
    pkt(2'd1, 32'hB10, 1, 4'h1, 2);
    wait_drain(100);

    // arb_enable dropped mid-packet on queue 3
    grant_q.push_back(2'd3);
    pkt(2'd3, 32'hE00, 3, 4'h2, 4);
    wait_grant(10);
    tick();
    arb_enable = 1'b0;
    grant_q.push_back(2'd0);
    pkt(2'd0, 32'hF00, 1, 4'h1, 2);
    wait_done(10);
    chk("t4_done_avail", 32'(dma_pkt_avail), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_grant",  32'(pkt_granted),   32'd0);
      chk("t4_no_avail",  32'(dma_pkt_avail), 32'd0);
    end
    arb_enable = 1'b1;
    tick();
    chk("t4_granted", 32'(pkt_granted), 32'd1);
    chk("t4_q_num",   32'(dma_q_num),   32'd0);
    wait_done(10);

    // Underrun in BODY of queue 1
    grant_q.push_back(2'd1);
    pkt(2'd1, 32'h200, 2, 4'h4, 3);
    wait_grant(10);
    tick();
    rdy_en[1] = 1'b0;
    #1;
    chk("t5_q_rd_blocked", 32'(q_rd),       32'd0);
    chk("t5_rd_rdy_low",   32'(dma_rd_rdy), 32'd0);
    tick();
    chk("t5_underrun_1",   32'(rd_underrun),   32'd1);
    chk("t5_still_locked", 32'(dma_pkt_avail), 32'd1);
    chk("t5_q_rd_blocked2", 32'(q_rd),         32'd0);
    tick();
    chk("t5_underrun_2",   32'(rd_underrun),   32'd1);
    rdy_en[1] = 1'b1;
    #1;
    chk("t5_q_rd_resume",  32'(q_rd), 32'b0010);
    tick();
    chk("t5_underrun_off", 32'(rd_underrun), 32'd0);
    wait_done(10);

    // Reset in BODY of queue 2, then queues 0 and 2 request
    grant_q.push_back(2'd2);
    pkt(2'd2, 32'h300, 3, 4'h1, 1);
    wait_grant(10);
    tick();
    reset  = 1'b1;
    dma_rd = 1'b0;
    tick();
    chk_all_zero("midreset");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    grant_q.push_back(2'd0);
    grant_q.push_back(2'd2);
    pkt(2'd0, 32'h400, 1, 4'h1, 2);
    pkt(2'd2, 32'h500, 1, 4'h1, 2);
    reset  = 1'b0;
    dma_rd = 1'b1;
    wait_grant(10);
    chk("t6_first_q0", 32'(dma_q_num), 32'd0);
    wait_drain(50);

    chk("end_grants_left", 32'(grant_q.size()), 32'd0);
    chk("end_done_pending", 32'(done_pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
